// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver and the upstream colour converter.
// Holds the controller state encoding, PWM resolution and the 24-bit colour field layout.
package rgb_pwm_driver_pkg;

  localparam int unsigned PWM_BITS  = 8;
  localparam int unsigned RGB_BITS  = 24;
  localparam int unsigned PRE_BITS  = 16;
  localparam int unsigned RGB_R_LSB = 16;
  localparam int unsigned RGB_G_LSB = 8;
  localparam int unsigned RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } rgb_t;

  // Extract one duty field from a packed colour word.
  function automatic logic [PWM_BITS-1:0] duty_of(input logic [RGB_BITS-1:0] rgb,
                                                   input int unsigned lsb);
    return rgb[lsb +: PWM_BITS];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: shadow duty register, count compare and registered LED drive.
// The shadow only changes on i_load so mid-period duty updates cannot glitch the output.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_run,
  input  logic [PWM_BITS-1:0] i_count,
  output logic                o_led
);

  logic [PWM_BITS-1:0] r_shadow;
  logic                r_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_led    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= i_duty;
      end
      r_led <= i_run && (i_count < r_shadow);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver with a prescaled 8-bit period counter.
// Duties are reloaded into per-channel shadows only at LOAD and at the period wrap.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [RGB_BITS-1:0] rgb,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                period_start
);

  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(PRESCALE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PWM_BITS-1:0] r_count;
  logic [PRE_BITS-1:0] r_pre;
  logic                r_period_start;
  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic                w_pstart;
  logic                w_run;
  rgb_t                w_rgb;

  // Next-state and per-cycle strobes; a falling enable always wins over a wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pstart    = 1'b0;
    w_tick      = (r_state == ST_RUN) && (r_pre == PRE_LAST);
    w_wrap      = w_tick && (r_count == {PWM_BITS{1'b1}});
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load = 1'b1;
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_pstart    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wrap) begin
          w_load   = 1'b1;
          w_pstart = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_pre          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_period_start <= w_pstart;
      // Count and prescaler only advance while staying in RUN.
      if ((r_state != ST_RUN) || !enable) begin
        r_count <= '0;
        r_pre   <= '0;
      end else if (w_tick) begin
        r_pre   <= '0;
        r_count <= r_count + PWM_BITS'(1);
      end else begin
        r_pre   <= r_pre + PRE_BITS'(1);
      end
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_rgb.r = duty_of(rgb, RGB_R_LSB);
  assign w_rgb.g = duty_of(rgb, RGB_G_LSB);
  assign w_rgb.b = duty_of(rgb, RGB_B_LSB);

  pwm_channel u_ch_r (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_duty  (w_rgb.r),
    .i_run   (w_run),
    .i_count (r_count),
    .o_led   (led_r)
  );

  pwm_channel u_ch_g (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_duty  (w_rgb.g),
    .i_run   (w_run),
    .i_count (r_count),
    .o_led   (led_g)
  );

  pwm_channel u_ch_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_duty  (w_rgb.b),
    .i_run   (w_run),
    .i_count (r_count),
    .o_led   (led_b)
  );

  assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=1, one at PRESCALE=4.
// Period windows start at the sample where period_start is seen high.
module tb_rgb_pwm_driver;

  logic        clk;
  logic        rst1, en1, r1, g1, b1, ps1;
  logic [23:0] rgb1;
  logic        rst4, en4, r4, g4, b4, ps4;
  logic [23:0] rgb4;

  int n_vec;
  int n_err;

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .rgb(rgb1),
    .led_r(r1), .led_g(g1), .led_b(b1), .period_start(ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .rgb(rgb4),
    .led_r(r4), .led_g(g4), .led_b(b4), .period_start(ps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps one period window, counting LED-high cycles; rgb is swapped to nxt mid-period.
  task automatic run_period(input bit sel, input int len, input logic [23:0] nxt,
                            output int hr, output int hg, output int hb,
                            output int mid, output bit pend);
    hr = 0; hg = 0; hb = 0; mid = 0; pend = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (i == len / 2) begin
        if (sel) rgb4 = nxt;
        else     rgb1 = nxt;
      end
      step();
      if (sel ? r4 : r1) hr++;
      if (sel ? g4 : g1) hg++;
      if (sel ? b4 : b1) hb++;
      if (i < len) begin
        if (sel ? ps4 : ps1) mid++;
      end else begin
        pend = sel ? ps4 : ps1;
      end
    end
  endtask

  task automatic check_period(input string tag, input bit sel, input int len,
                              input logic [23:0] nxt, input int er, input int eg, input int eb);
    int  hr, hg, hb, mid;
    bit  pend;
    run_period(sel, len, nxt, hr, hg, hb, mid, pend);
    check({tag, "_r_high"}, 32'(hr), 32'(er));
    check({tag, "_g_high"}, 32'(hg), 32'(eg));
    check({tag, "_b_high"}, 32'(hb), 32'(eb));
    check({tag, "_ps_mid"}, 32'(mid), 32'd0);
    check({tag, "_ps_end"}, 32'(pend), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst1 = 1'b1; en1 = 1'b1; rgb1 = 24'hFFFFFF;
    rst4 = 1'b1; en4 = 1'b1; rgb4 = 24'hFFFFFF;
    repeat (3) step();
    check("rst_leds1", 32'({r1, g1, b1}), 32'd0);
    check("rst_ps1", 32'(ps1), 32'd0);
    check("rst_leds4", 32'({r4, g4, b4, ps4}), 32'd0);

    // Black at PRESCALE=1: period_start on the second edge after release.
    rgb1 = 24'h000000;
    rst1 = 1'b0;
    step();
    check("start_ps_e1", 32'(ps1), 32'd0);
    step();
    check("start_ps_e2", 32'(ps1), 32'd1);
    check_period("black", 1'b0, 256, 24'hFF8000, 0, 0, 0);
    check_period("ff8000", 1'b0, 256, 24'h0000FF, 255, 128, 0);
    check_period("blue_ff", 1'b0, 256, 24'h000010, 0, 0, 255);
    check_period("blue_10", 1'b0, 256, 24'hFFFFFF, 0, 0, 16);

    // Drop enable at count=100 with all channels full.
    repeat (100) step();
    check("c100_r", 32'(r1), 32'd1);
    en1 = 1'b0;
    step();
    check("idle_entry_r", 32'(r1), 32'd1);
    step();
    check("idle_leds", 32'({r1, g1, b1}), 32'd0);
    check("idle_ps", 32'(ps1), 32'd0);
    repeat (3) step();
    check("idle_hold_leds", 32'({r1, g1, b1, ps1}), 32'd0);
    en1 = 1'b1;
    step();
    check("reen_load_ps", 32'(ps1), 32'd0);
    step();
    check("reen_run_ps", 32'(ps1), 32'd1);
    check_period("white", 1'b0, 256, 24'hFFFFFF, 255, 255, 255);

    // Enable falls on the wrap edge: no period_start pulse.
    repeat (255) step();
    en1 = 1'b0;
    step();
    check("wrap_drop_ps", 32'(ps1), 32'd0);
    step();
    check("wrap_drop_leds", 32'({r1, g1, b1}), 32'd0);

    // Reset mid-RUN with white.
    en1 = 1'b1;
    step();
    step();
    check("pre_rst_ps", 32'(ps1), 32'd1);
    repeat (50) step();
    check("pre_rst_r", 32'(r1), 32'd1);
    rst1 = 1'b1;
    step();
    check("midrst_outs", 32'({r1, g1, b1, ps1}), 32'd0);
    rst1 = 1'b0;
    step();
    check("post_rst_e1_ps", 32'(ps1), 32'd0);
    step();
    check("post_rst_e2_ps", 32'(ps1), 32'd1);

    // PRESCALE=4, green full.
    rgb4 = 24'h00FF00;
    rst4 = 1'b0;
    step();
    check("p4_ps_e1", 32'(ps4), 32'd0);
    step();
    check("p4_ps_e2", 32'(ps4), 32'd1);
    check_period("p4_green", 1'b1, 1024, 24'h00FF00, 0, 1020, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
